// File: rtl/mistral_mul_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : mistral_mul_seq_if
// Description : Operand/product handshake bundle for the mistral_mul_seq
//               iterative multiplier. The master drives operands and
//               accepts products. The slave is the multiplier.
//               With MISTRAL_MUL_SEQ_SIGNED_EN defined, the bundle also
//               carries a per-operation is_signed flag.
// Revision    : 1.0 - initial release
// ============================================================================
interface mistral_mul_seq_if #(
    parameter int TILE_WIDTH = 27,
    parameter int TILES      = 2
);
    localparam int c_w = TILE_WIDTH * TILES;

    // Operand channel
    logic             in_valid;
    logic             in_ready;
    logic [c_w-1:0]   a;
    logic [c_w-1:0]   b;
`ifdef MISTRAL_MUL_SEQ_SIGNED_EN
    logic             is_signed;
`endif

    // Product channel
    logic             out_valid;
    logic             out_ready;
    logic [2*c_w-1:0] y;

`ifdef MISTRAL_MUL_SEQ_SIGNED_EN
    modport master (
        output in_valid, a, b, is_signed, out_ready,
        input  in_ready, out_valid, y
    );
    modport slave (
        input  in_valid, a, b, is_signed, out_ready,
        output in_ready, out_valid, y
    );
`else
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, y
    );
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, y
    );
`endif
endinterface
`default_nettype wire

// File: rtl/mistral_mul_seq.sv
`default_nettype none
// ============================================================================
// Module      : mistral_mul_seq
// Description : Iterative wide multiplier. Splits two W-bit operands
//               (W = TILE_WIDTH*TILES) into TILE_WIDTH-bit tiles and runs
//               one tile x tile partial product per cycle through a single
//               multiply. Each partial product is shift-accumulated into a
//               2W-bit product. Uses an IDLE -> MUL -> DONE handshake FSM.
//               Optional: MISTRAL_MUL_SEQ_SIGNED_EN adds a two's-complement
//               mode that is selected per operation.
// Revision    : 1.0 - initial release
// ============================================================================
module mistral_mul_seq #(
    parameter int TILE_WIDTH = 27,
    parameter int TILES      = 2
) (
    input  logic              clk,
    input  logic              aclr,
    mistral_mul_seq_if.slave  bus
);
    localparam int c_w  = TILE_WIDTH * TILES;
    localparam int c_pw = 2 * c_w;
    localparam int c_iw = (TILES > 1) ? $clog2(TILES) : 1;
    localparam int c_sw = $clog2(c_pw) + 1;

    localparam logic [c_iw-1:0] c_last   = c_iw'(TILES - 1);
    localparam logic [c_sw-1:0] c_tw_sh  = c_sw'(TILE_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                w_in_ready;
    logic                w_out_valid;

    logic [c_w-1:0]      r_a;
    logic [c_w-1:0]      r_b;
    logic [c_pw-1:0]     r_acc;
    logic [c_iw-1:0]     r_ia;
    logic [c_iw-1:0]     r_ib;
`ifdef MISTRAL_MUL_SEQ_SIGNED_EN
    logic                r_signed;
`endif

    logic                w_last;
    logic                w_accept;
    logic [TILE_WIDTH-1:0] w_a_tiles [TILES];
    logic [TILE_WIDTH-1:0] w_b_tiles [TILES];
    logic [TILE_WIDTH-1:0] w_a_tile;
    logic [TILE_WIDTH-1:0] w_b_tile;
    logic                w_a_ext;
    logic                w_b_ext;
    logic signed [2*TILE_WIDTH+1:0] w_pp_full;
    logic [c_pw-1:0]     w_pp;
    logic [c_sw-1:0]     w_sh;
    logic [c_pw-1:0]     w_acc_next;

    // ------------------------------------------------------------------
    // Tile slicing of the latched operands
    // ------------------------------------------------------------------
    for (genvar g = 0; g < TILES; g++) begin : g_tile
        assign w_a_tiles[g] = r_a[g*TILE_WIDTH +: TILE_WIDTH];
        assign w_b_tiles[g] = r_b[g*TILE_WIDTH +: TILE_WIDTH];
    end

    assign w_a_tile = w_a_tiles[r_ia];
    assign w_b_tile = w_b_tiles[r_ib];

    // The extension bit is the tile's sign only for the top tile of a
    // signed operation. Every other tile is zero-extended, so one signed
    // (TILE_WIDTH+1)-bit multiply covers all four signedness combinations.
`ifdef MISTRAL_MUL_SEQ_SIGNED_EN
    assign w_a_ext = r_signed & (r_ia == c_last) & w_a_tile[TILE_WIDTH-1];
    assign w_b_ext = r_signed & (r_ib == c_last) & w_b_tile[TILE_WIDTH-1];
`else
    assign w_a_ext = 1'b0;
    assign w_b_ext = 1'b0;
`endif

    assign w_pp_full  = $signed({w_a_ext, w_a_tile}) * $signed({w_b_ext, w_b_tile});
    // The size cast sign-extends, or truncates when TILES=1. Both are
    // correct modulo 2^(2W).
    assign w_pp       = c_pw'(w_pp_full);
    assign w_sh       = c_tw_sh * (c_sw'(r_ia) + c_sw'(r_ib));
    assign w_acc_next = r_acc + (w_pp << w_sh);

    assign w_last     = (r_ia == c_last) && (r_ib == c_last);
    assign w_accept   = (r_state == IDLE) && bus.in_valid;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_next = MUL;
                end
            end
            MUL: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand latch, tile walk and shift-accumulate datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_ia  <= '0;
            r_ib  <= '0;
`ifdef MISTRAL_MUL_SEQ_SIGNED_EN
            r_signed <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a   <= bus.a;
            r_b   <= bus.b;
            r_acc <= '0;
            r_ia  <= '0;
            r_ib  <= '0;
`ifdef MISTRAL_MUL_SEQ_SIGNED_EN
            r_signed <= bus.is_signed;
`endif
        end else if (r_state == MUL) begin
            r_acc <= w_acc_next;
            // The inner index runs over B tiles and the outer index runs
            // over A tiles. Both indices return to zero after the last
            // partial product.
            if (w_last) begin
                r_ia <= '0;
                r_ib <= '0;
            end else if (r_ib == c_last) begin
                r_ib <= '0;
                r_ia <= r_ia + 1'b1;
            end else begin
                r_ib <= r_ib + 1'b1;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.y         = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_mistral_mul_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mistral_mul_seq
// Description : Directed self-checking bench for mistral_mul_seq with the
//               default parameters (TILE_WIDTH=27, TILES=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mistral_mul_seq;
    localparam int TW = 27;
    localparam int NT = 2;
    localparam int W  = TW * NT;
    localparam int PW = 2 * W;
    localparam int LAT = NT * NT;

    logic clk  = 1'b0;
    logic aclr = 1'b0;
    int   total = 0;
    int   bad   = 0;

    mistral_mul_seq_if #(.TILE_WIDTH(TW), .TILES(NT)) bus ();

    mistral_mul_seq #(.TILE_WIDTH(TW), .TILES(NT)) dut (
        .clk  (clk),
        .aclr (aclr),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle into the sampling/drive window.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present one operand pair for one edge, then count the edges until
    // out_valid appears. out_ready is left low.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          output logic [PW-1:0] yv, output int lat);
        bus.a        = av;
        bus.b        = bv;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 30) begin
            tick();
            lat++;
        end
        yv = bus.y;
    endtask

    task automatic release_out;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        total++; if (bus.y !== '0) begin bad++; $display("FAIL reset_y: got %0h want 0", bus.y); end
        @(negedge clk);
        aclr = 1'b1;
        tick();
    endtask

    task automatic test_basic;
        int n;
        bus.a = W'(1); bus.b = W'(1); bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 30) begin
            total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL basic_busy_in_ready: got %b want 0 at cycle %0d", bus.in_ready, n); end
            tick();
            n++;
        end
        total++; if (n !== LAT) begin bad++; $display("FAIL basic_latency: got %0d want %0d", n, LAT); end
        total++; if (bus.y !== PW'(1)) begin bad++; $display("FAIL basic_y: got %0h want 1", bus.y); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL basic_done_in_ready: got %b want 0", bus.in_ready); end
        release_out();
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL basic_post_in_ready: got %b want 1", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL basic_post_out_valid: got %b want 0", bus.out_valid); end
        total++; if (bus.y !== PW'(1)) begin bad++; $display("FAIL basic_post_y_hold: got %0h want 1", bus.y); end
    endtask

    task automatic test_full_scale;
        logic [PW-1:0] yv;
        logic [PW-1:0] ev;
        int lat;
        // (2^54-1)^2 = 2^108 - 2^55 + 1, which wraps to -2^55 + 1 in 108 bits
        ev = PW'(0) - (PW'(1) << 55) + PW'(1);
        run_op({W{1'b1}}, {W{1'b1}}, yv, lat);
        total++; if (yv !== ev) begin bad++; $display("FAIL full_scale_y: got %0h want %0h", yv, ev); end
        total++; if (lat !== LAT) begin bad++; $display("FAIL full_scale_latency: got %0d want %0d", lat, LAT); end
        release_out();
        run_op(W'(1) << 27, W'(1) << 27, yv, lat);
        total++; if (yv !== (PW'(1) << 54)) begin bad++; $display("FAIL cross_tile_y: got %0h want %0h", yv, PW'(1) << 54); end
        release_out();
    endtask

    task automatic test_backpressure;
        logic [PW-1:0] yv;
        int lat;
        run_op(W'(6), W'(7), yv, lat);
        for (int i = 0; i < 10; i++) begin
            bus.a        = W'({$urandom(), $urandom()});
            bus.b        = W'({$urandom(), $urandom()});
            bus.in_valid = 1'($urandom_range(0, 1));
            tick();
            total++; if (bus.y !== PW'(42)) begin bad++; $display("FAIL bp_y_stable: got %0h want 2a cycle %0d", bus.y, i); end
            total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid: got %b want 1 cycle %0d", bus.out_valid, i); end
            total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got %b want 0 cycle %0d", bus.in_ready, i); end
        end
        bus.in_valid = 1'b0;
        release_out();
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_in_ready: got %b want 1", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_out_valid: got %b want 0", bus.out_valid); end
        run_op(W'(9), W'(9), yv, lat);
        total++; if (yv !== PW'(81)) begin bad++; $display("FAIL bp_next_y: got %0h want 51", yv); end
        total++; if (lat !== LAT) begin bad++; $display("FAIL bp_next_latency: got %0d want %0d", lat, LAT); end
        release_out();
    endtask

    task automatic test_reset_mid;
        logic [PW-1:0] yv;
        int lat;
        bus.a = W'(100); bus.b = W'(200); bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        #2;
        aclr = 1'b0;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready: got %b want 1", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid: got %b want 0", bus.out_valid); end
        total++; if (bus.y !== '0) begin bad++; $display("FAIL midrst_y: got %0h want 0", bus.y); end
        @(negedge clk);
        aclr = 1'b1;
        tick();
        run_op(W'(3), W'(5), yv, lat);
        total++; if (yv !== PW'(15)) begin bad++; $display("FAIL midrst_after_y: got %0h want f", yv); end
        total++; if (lat !== LAT) begin bad++; $display("FAIL midrst_after_latency: got %0d want %0d", lat, LAT); end
        release_out();
    endtask

    task automatic test_back_to_back;
        logic [W-1:0]  qa [8];
        logic [W-1:0]  qb [8];
        logic [PW-1:0] ex [8];
        int i, j, cyc, last;
        for (int k = 0; k < 8; k++) begin
            qa[k] = W'({$urandom(), $urandom()});
            qb[k] = W'({$urandom(), $urandom()});
            ex[k] = PW'(qa[k]) * PW'(qb[k]);
        end
        bus.out_ready = 1'b1;
        i = 0; j = 0; cyc = 0; last = 0;
        while (j < 8 && cyc < 200) begin
            if (bus.out_valid) begin
                total++; if (bus.y !== ex[j]) begin bad++; $display("FAIL b2b_y[%0d]: got %0h want %0h", j, bus.y, ex[j]); end
                if (j > 0) begin
                    total++; if (cyc - last !== LAT + 2) begin bad++; $display("FAIL b2b_spacing[%0d]: got %0d want %0d", j, cyc - last, LAT + 2); end
                end
                last = cyc;
                j++;
            end
            if (bus.in_ready) begin
                if (i < 8) begin
                    bus.a = qa[i]; bus.b = qb[i]; bus.in_valid = 1'b1;
                    i++;
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            tick();
            cyc++;
        end
        total++; if (j !== 8) begin bad++; $display("FAIL b2b_count: got %0d want 8", j); end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
    endtask

`ifdef MISTRAL_MUL_SEQ_SIGNED_EN
    task automatic test_signed;
        logic [PW-1:0] yv;
        int lat;
        bus.is_signed = 1'b1;
        run_op({W{1'b1}}, W'(3), yv, lat);
        total++; if (yv !== PW'(0) - PW'(3)) begin bad++; $display("FAIL signed_m1x3: got %0h want %0h", yv, PW'(0) - PW'(3)); end
        release_out();
        run_op(W'(1) << 53, W'(1) << 53, yv, lat);
        total++; if (yv !== (PW'(1) << 106)) begin bad++; $display("FAIL signed_minsq: got %0h want %0h", yv, PW'(1) << 106); end
        release_out();
        bus.is_signed = 1'b0;
        run_op({W{1'b1}}, W'(3), yv, lat);
        total++; if (yv !== PW'(3) * PW'({W{1'b1}})) begin bad++; $display("FAIL unsigned_ones_x3: got %0h want %0h", yv, PW'(3) * PW'({W{1'b1}})); end
        release_out();
    endtask
`endif

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
`ifdef MISTRAL_MUL_SEQ_SIGNED_EN
        bus.is_signed = 1'b0;
`endif
        test_reset();
        test_basic();
        test_full_scale();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
`ifdef MISTRAL_MUL_SEQ_SIGNED_EN
        test_signed();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
